// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the sequential restoring divider.
package divider_pkg;
   localparam int N_DEF = 8;
   localparam int CNT_W = $clog2(2 * N_DEF);
   localparam logic [2*N_DEF-1:0] Q_ONES = '1;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on an (N+1)-bit partial remainder.
module div_step #(
   parameter int N = 8
) (
   input  logic [N:0]   p,
   input  logic [N-1:0] divisor,
   input  logic         bit_in,
   output logic [N:0]   p_next,
   output logic         q
);
   logic [N:0] sh;
   always_comb begin
      sh = {p[N-1:0], bit_in};
      // p[N] is only ever set with a zero divisor, where the shifted value still dominates
      q = p[N] | (sh >= {1'b0, divisor});
      p_next = q ? sh - {1'b0, divisor} : sh;
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: 2N/N unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_ERR_EN to short-circuit a zero divisor with an err flag.
module seq_divider
   import divider_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           err
);
   localparam int CW = $clog2(2 * N);
   state_t         state;
   logic [CW-1:0]  count;
   logic [2*N-1:0] dvd;
   logic [N-1:0]   dvs;
   logic [N:0]     p, p_next;
   logic           q_bit;
   div_step #(.N(N)) u_step (
      .p(p), .divisor(dvs), .bit_in(dvd[2*N-1]), .p_next(p_next), .q(q_bit)
   );
`ifdef DIVIDER_ERR_EN
   logic err_r, zero_pend;
   assign err = err_r;
`else
   assign err = 1'b0;
`endif
   // dvd doubles as the quotient accumulator: dividend bits leave at the top, quotient bits enter at the bottom
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         count     <= '0;
         dvd       <= '0;
         dvs       <= '0;
         p         <= '0;
`ifdef DIVIDER_ERR_EN
         err_r     <= 1'b0;
         zero_pend <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
`ifdef DIVIDER_ERR_EN
            if (zero_pend) begin
               zero_pend <= 1'b0;
               done      <= 1'b1;
               err_r     <= 1'b1;
               quotient  <= '1;
               remainder <= dvd[N-1:0];
            end else
`endif
            if (start) begin
               dvd   <= dividend;
               dvs   <= divisor;
               p     <= '0;
               count <= '0;
`ifdef DIVIDER_ERR_EN
               err_r <= 1'b0;
               if (divisor == '0) zero_pend <= 1'b1;
               else begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
`else
               state <= RUN;
               busy  <= 1'b1;
`endif
            end
         end else begin
            p     <= p_next;
            dvd   <= {dvd[2*N-2:0], q_bit};
            count <= count + 1'b1;
            if (count == CW'(2*N-1)) begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b1;
               quotient  <= {dvd[2*N-2:0], q_bit};
               remainder <= p_next[N-1:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider (honours DIVIDER_ERR_EN).
module tb_seq_divider;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        busy, done, err;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   int vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   seq_divider dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .err(err)
   );

   task automatic launch(input logic [15:0] a, input logic [7:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // edges counted from the accepting edge (1) to the edge that raises done
   task automatic wait_done(output int e);
      e = 1;
      while (done !== 1'b1 && e < 40) begin
         @(posedge clk);
         #1 e++;
      end
   endtask

   task automatic test_reset;
      #2;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err); end
      vectors++; if (quotient !== 16'h0) begin miscompares++; $display("FAIL reset_quot got %0h want 0", quotient); end
      vectors++; if (remainder !== 8'h0) begin miscompares++; $display("FAIL reset_rem got %0h want 0", remainder); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int e;
      launch(16'd289, 8'd17);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %0b want 1", busy); end
      wait_done(e);
      vectors++; if (e != 17) begin miscompares++; $display("FAIL basic_latency got %0d want 17", e); end
      vectors++; if (quotient !== 16'd17) begin miscompares++; $display("FAIL basic_quot got %0d want 17", quotient); end
      vectors++; if (remainder !== 8'd0) begin miscompares++; $display("FAIL basic_rem got %0d want 0", remainder); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_done got %0b want 0", busy); end
      @(posedge clk);
      #1;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %0b want 0", done); end
   endtask

   task automatic test_back_to_back;
      int e;
      launch(16'hFFFF, 8'hFF);
      wait_done(e);
      vectors++; if (e != 17) begin miscompares++; $display("FAIL b2b_latency1 got %0d want 17", e); end
      vectors++; if (quotient !== 16'd257) begin miscompares++; $display("FAIL b2b_quot1 got %0d want 257", quotient); end
      vectors++; if (remainder !== 8'd0) begin miscompares++; $display("FAIL b2b_rem1 got %0d want 0", remainder); end
      dividend = 16'd1000;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got %0b want 1", busy); end
      vectors++; if (quotient !== 16'd257) begin miscompares++; $display("FAIL b2b_hold got %0d want 257", quotient); end
      wait_done(e);
      vectors++; if (e != 17) begin miscompares++; $display("FAIL b2b_latency2 got %0d want 17", e); end
      vectors++; if (quotient !== 16'd142) begin miscompares++; $display("FAIL b2b_quot2 got %0d want 142", quotient); end
      vectors++; if (remainder !== 8'd6) begin miscompares++; $display("FAIL b2b_rem2 got %0d want 6", remainder); end
   endtask

   task automatic test_busy_ignore;
      int e;
      launch(16'h00FF, 8'h01);
      e = 1;
      while (done !== 1'b1 && e < 40) begin
         if (e == 5) begin
            dividend = 16'h1234;
            divisor  = 8'h03;
            start    = 1'b1;
         end else start = 1'b0;
         @(posedge clk);
         #1 e++;
      end
      start = 1'b0;
      vectors++; if (e != 17) begin miscompares++; $display("FAIL ignore_latency got %0d want 17", e); end
      vectors++; if (quotient !== 16'd255) begin miscompares++; $display("FAIL ignore_quot got %0d want 255", quotient); end
      vectors++; if (remainder !== 8'd0) begin miscompares++; $display("FAIL ignore_rem got %0d want 0", remainder); end
   endtask

   task automatic test_div_zero;
      int e;
      launch(16'd5, 8'd0);
`ifdef DIVIDER_ERR_EN
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %0b want 0", busy); end
`endif
      wait_done(e);
`ifdef DIVIDER_ERR_EN
      vectors++; if (e != 2) begin miscompares++; $display("FAIL zero_latency got %0d want 2", e); end
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL zero_err got %0b want 1", err); end
`else
      vectors++; if (e != 17) begin miscompares++; $display("FAIL zero_latency got %0d want 17", e); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL zero_err got %0b want 0", err); end
`endif
      vectors++; if (quotient !== 16'hFFFF) begin miscompares++; $display("FAIL zero_quot got %0h want ffff", quotient); end
      vectors++; if (remainder !== 8'd5) begin miscompares++; $display("FAIL zero_rem got %0d want 5", remainder); end
   endtask

   task automatic test_reset_mid;
      int e;
      bit seen = 1'b0;
      launch(16'd1000, 8'd7);
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %0b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %0b want 0", done); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL abort_err got %0b want 0", err); end
      vectors++; if (quotient !== 16'h0) begin miscompares++; $display("FAIL abort_quot got %0h want 0", quotient); end
      vectors++; if (remainder !== 8'h0) begin miscompares++; $display("FAIL abort_rem got %0h want 0", remainder); end
      @(negedge clk) rst_n = 1'b1;
      repeat (25) begin
         @(posedge clk);
         #1 if (done === 1'b1) seen = 1'b1;
      end
      vectors++; if (seen) begin miscompares++; $display("FAIL abort_no_done got 1 want 0"); end
      launch(16'd100, 8'd9);
      wait_done(e);
      vectors++; if (e != 17) begin miscompares++; $display("FAIL after_abort_latency got %0d want 17", e); end
      vectors++; if (quotient !== 16'd11) begin miscompares++; $display("FAIL after_abort_quot got %0d want 11", quotient); end
      vectors++; if (remainder !== 8'd1) begin miscompares++; $display("FAIL after_abort_rem got %0d want 1", remainder); end
   endtask

   task automatic test_random;
      int e;
      logic [15:0] a;
      logic [7:0]  b;
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = 8'($urandom_range(1, 255));
         launch(a, b);
         wait_done(e);
         vectors++;
         if (e != 17 || quotient !== a / 16'(b) || remainder !== 8'(a % 16'(b)) ||
             32'(quotient) * 32'(b) + 32'(remainder) != 32'(a) || remainder >= b) begin
            miscompares++;
            $display("FAIL random %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=17",
                     a, b, quotient, remainder, e, a / 16'(b), a % 16'(b));
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_busy_ignore;
      test_div_zero;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
